rule_conf_arb: RTL and testbench

RULE_CONF_ARB -- requirements
Module: rule_conf_arb

---
 rtl/rule_conf_arb_pkg.sv | 32 +++
 rtl/rule_conf_arb_rr_arb2.sv | 21 ++
 rtl/rule_conf_arb.sv | 166 ++++++++++++++++
 tb/tb_rule_conf_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule_conf_arb_pkg.sv
// Shared parser definitions: configuration sub-target codes carried in
// addr[10:8], the highest legal code, and the arbiter FSM state encoding.
package rule_conf_arb_pkg;

  // Sub-target selected by addr[10:8] of a configuration beat.
  typedef enum logic [2:0] {
    SUB_RULE           = 3'd0,
    SUB_TYPE_DATA_MASK = 3'd1,
    SUB_TYPE_OFFSET    = 3'd2,
    SUB_KEY_OFFSET     = 3'd3,
    SUB_HEAD_SHIFT     = 3'd4,
    SUB_META_SHIFT     = 3'd5
  } sub_target_e;

  // Codes above this value address nothing and are dropped.
  localparam logic [2:0] MAX_LEGAL_CODE = 3'd5;

  // Width of the mid-burst idle counter; covers the full TIMEOUT_CYC range.
  localparam int IDLE_CNT_W = 16;

  // Arbiter FSM: waiting for a requester, or locked to one for a burst.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // True when the beat address selects an existing sub-target.
  function automatic logic addr_is_legal(input logic [31:0] addr);
    return addr[10:8] <= MAX_LEGAL_CODE;
  endfunction

endpackage

// File: rtl/rule_conf_arb_rr_arb2.sv
// Two-way round-robin picker: with a single request it grants that one,
// with both requesting it grants the requester named by rr_i.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic       any_o,
  output logic       gnt_o
);

  // Pure combinational pick; the caller samples gnt_o only when any_o is high.
  always_comb begin
    any_o = |req_i;
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = rr_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/rule_conf_arb.sv
// Configuration-write arbiter. Two requesters (0 = host CPU, 1 = boot
// loader) send bursts of configuration beats; one burst at a time is
// forwarded to the rule configuration block as registered write strobes.
// A burst ends on its last beat or after TIMEOUT_CYC-1 beat-less cycles.
//
// Handshake: a beat transfers on a cycle where i_req_valid[g] and
// o_req_ready[g] are both high; ready depends only on registered state
// (never on valid), only the granted requester ever sees ready, and a
// transferred beat appears on o_rule_* exactly one cycle later.
module rule_conf_arb
  import rule_conf_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_valid,
  input  logic [1:0][31:0]     i_req_wdata,
  input  logic [1:0][31:0]     i_req_addr,
  input  logic [1:0]           i_req_last,
  output logic [1:0]           o_req_ready,
  output logic                 o_rule_wren,
  output logic [31:0]          o_rule_wdata,
  output logic [31:0]          o_rule_addr,
  output logic                 o_busy,
  output logic                 o_grant,
  output logic [CNT_WIDTH-1:0] o_drop_cnt,
  output logic [CNT_WIDTH-1:0] o_abort_cnt
);

  // Idle count at which one more empty cycle reaches TIMEOUT_CYC-1.
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(TIMEOUT_CYC - 2);

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   rr_q, rr_d;
  logic [IDLE_CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic                   wren_q, wren_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]   abort_cnt_q, abort_cnt_d;

  logic                   arb_any;
  logic                   arb_gnt;
  logic                   in_burst;
  logic                   beat_acc;
  logic                   beat_last;
  logic [31:0]            beat_addr;
  logic [31:0]            beat_data;
  logic                   beat_legal;
  logic                   timeout_hit;

  rr_arb2 u_rr_arb2 (
    .req_i (i_req_valid),
    .rr_i  (rr_q),
    .any_o (arb_any),
    .gnt_o (arb_gnt)
  );

  // Beat qualification for the requester that currently owns the burst.
  always_comb begin
    in_burst    = (state_q == ST_BURST);
    beat_acc    = in_burst && i_req_valid[grant_q];
    beat_last   = i_req_last[grant_q];
    beat_addr   = i_req_addr[grant_q];
    beat_data   = i_req_wdata[grant_q];
    beat_legal  = addr_is_legal(beat_addr);
    // A beat on the would-be timeout cycle wins: timeout needs no acceptance.
    timeout_hit = in_burst && !beat_acc && (idle_cnt_q == IDLE_LIMIT);
  end

  // Next-state logic for the FSM, round-robin pointer and idle counter.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    idle_cnt_d  = idle_cnt_q;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d    = ST_BURST;
          grant_d    = arb_gnt;
          idle_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (beat_acc) begin
          idle_cnt_d = '0;
          if (beat_last) begin
            state_d = ST_IDLE;
            rr_d    = ~grant_q;
          end
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          rr_d       = ~grant_q;
          idle_cnt_d = '0;
          if (abort_cnt_q != '1) begin
            abort_cnt_d = abort_cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write-path next state: register accepted beats, count illegal ones.
  always_comb begin
    wren_d     = beat_acc && beat_legal;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    drop_cnt_d = drop_cnt_q;
    if (beat_acc) begin
      wdata_d = beat_data;
      addr_d  = beat_addr;
      if (!beat_legal && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers; reset clears everything, including a pending write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      idle_cnt_q  <= '0;
      wren_q      <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      drop_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      idle_cnt_q  <= idle_cnt_d;
      wren_q      <= wren_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      drop_cnt_q  <= drop_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  // Outputs come straight from registers; ready goes to the owner only.
  always_comb begin
    o_req_ready  = 2'b00;
    o_req_ready[grant_q] = in_burst;
    o_rule_wren  = wren_q;
    o_rule_wdata = wdata_q;
    o_rule_addr  = addr_q;
    o_busy       = in_burst;
    o_grant      = grant_q;
    o_drop_cnt   = drop_cnt_q;
    o_abort_cnt  = abort_cnt_q;
  end

endmodule

// File: tb/tb_rule_conf_arb.sv
// Bench for rule_conf_arb: directed vector table, hand-written timeout,
// reset and saturation sequences, and randomized traffic against a
// transaction-level reference model.
module tb_rule_conf_arb;

  localparam int TO   = 4;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic [1:0]      valid;
  logic [1:0]      last;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] addr;
  logic [1:0]      ready;
  logic            wren;
  logic [31:0]     r_wdata;
  logic [31:0]     r_addr;
  logic            busy;
  logic            grant;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   abort_cnt;

  rule_conf_arb #(.TIMEOUT_CYC(TO), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (valid),
    .i_req_wdata  (wdata),
    .i_req_addr   (addr),
    .i_req_last   (last),
    .o_req_ready  (ready),
    .o_rule_wren  (wren),
    .o_rule_wdata (r_wdata),
    .o_rule_addr  (r_addr),
    .o_busy       (busy),
    .o_grant      (grant),
    .o_drop_cnt   (drop_cnt),
    .o_abort_cnt  (abort_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus, how long it has been silent,
  // the statistics, and the writes still owed to the rule block.
  bit   m_busy;
  int   m_owner;
  int   m_rr;
  int   m_idle;
  int   m_drop;
  int   m_abort;
  bit   m_wren;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_idle = 0;
    m_drop = 0; m_abort = 0; m_wren = 0;
    exp_q.delete();
  endtask

  // One clock of the model, using the inputs presented before the edge.
  task automatic model_edge();
    m_wren = 0;
    if (!m_busy) begin
      if (valid != 2'b00) begin
        if (valid == 2'b11) m_owner = m_rr;
        else m_owner = valid[0] ? 0 : 1;
        m_busy = 1;
        m_idle = 0;
      end
    end else if (valid[m_owner]) begin
      if (addr[m_owner][10:8] <= 3'd5) begin
        m_wren = 1;
        exp_q.push_back({addr[m_owner], wdata[m_owner]});
      end else if (m_drop < MAXC) begin
        m_drop++;
      end
      m_idle = 0;
      if (last[m_owner]) begin
        m_busy = 0;
        m_rr   = 1 - m_owner;
      end
    end else begin
      m_idle++;
      if (m_idle == TO - 1) begin
        m_busy = 0;
        m_rr   = 1 - m_owner;
        if (m_abort < MAXC) m_abort++;
      end
    end
  endtask

  task automatic compare_model();
    logic [63:0] e;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant", 32'(grant), 32'(m_owner));
    chk("ready", 32'(ready), 32'(m_busy ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00));
    chk("wren", 32'(wren), 32'(m_wren));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
    if (m_wren && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_addr", r_addr, e[63:32]);
      chk("wr_data", r_wdata, e[31:0]);
    end
  endtask

  // Driver: advance one clock; inputs are held from the previous call.
  task automatic cycle(input bit do_chk);
    model_edge();
    @(posedge clk);
    #1;
    if (do_chk) compare_model();
    else if (m_wren && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; last = '0; addr = '0; wdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_wren"}, 32'(wren), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_wdata"}, r_wdata, 32'd0);
    chk({tag, "_addr"}, r_addr, 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_abort"}, 32'(abort_cnt), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  l;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [1:0]  e_ready;
    logic        e_wren;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_grant;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Requester 1 holds a one-beat illegal burst (0x600) throughout.
    tbl[0] = '{2'b11, 2'b10, 32'h100, 32'hA1, 2'b01, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 16'd0};
    tbl[1] = '{2'b11, 2'b10, 32'h100, 32'hA1, 2'b01, 1'b1, 32'h100, 32'hA1, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{2'b11, 2'b10, 32'h200, 32'hA2, 2'b01, 1'b1, 32'h200, 32'hA2, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{2'b11, 2'b11, 32'h000, 32'hA3, 2'b00, 1'b1, 32'h000, 32'hA3, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{2'b11, 2'b11, 32'h300, 32'hA4, 2'b10, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 16'd0};
    tbl[5] = '{2'b11, 2'b11, 32'h300, 32'hA4, 2'b00, 1'b0, 32'h0,   32'h0,  1'b0, 1'b1, 16'd1};
    tbl[6] = '{2'b00, 2'b00, 32'h300, 32'hA4, 2'b00, 1'b0, 32'h0,   32'h0,  1'b0, 1'b1, 16'd1};

    do_reset();
    chk_reset_outputs("reset");

    // Directed table: arbitration, lock, write timing, illegal drop.
    for (int i = 0; i < 7; i++) begin
      valid = tbl[i].v; last = tbl[i].l;
      addr[0] = tbl[i].a0; wdata[0] = tbl[i].d0;
      addr[1] = 32'h600;   wdata[1] = 32'hB1;
      cycle(1'b1);
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_wren", i), 32'(wren), 32'(tbl[i].e_wren));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
      if (tbl[i].e_wren) begin
        chk($sformatf("tbl%0d_waddr", i), r_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_wdata", i), r_wdata, tbl[i].e_data);
      end
    end

    // Timeout: one non-last beat, then silence for three BURST cycles.
    valid = 2'b01; last = 2'b00; addr[0] = 32'h100; wdata[0] = 32'h11;
    cycle(1'b1);
    cycle(1'b1);
    chk("to_beat_wren", 32'(wren), 32'd1);
    valid = 2'b00;
    cycle(1'b1);
    cycle(1'b1);
    chk("to_still_busy", 32'(busy), 32'd1);
    cycle(1'b1);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_abort", 32'(abort_cnt), 32'd1);
    valid = 2'b11; last = 2'b00; addr[1] = 32'h100;
    cycle(1'b1);
    chk("to_rr_next", 32'(grant), 32'd1);
    valid = 2'b10; last = 2'b10; wdata[1] = 32'h22;
    cycle(1'b1);
    valid = 2'b00;
    cycle(1'b1);

    // Last beat lands exactly on the would-be timeout cycle.
    valid = 2'b01; last = 2'b00; addr[0] = 32'h200; wdata[0] = 32'h31;
    cycle(1'b1);
    cycle(1'b1);
    valid = 2'b00;
    cycle(1'b1);
    cycle(1'b1);
    valid = 2'b01; last = 2'b01; addr[0] = 32'h300; wdata[0] = 32'h33;
    cycle(1'b1);
    chk("edge_wren", 32'(wren), 32'd1);
    chk("edge_addr", r_addr, 32'h300);
    chk("edge_abort", 32'(abort_cnt), 32'd1);
    chk("edge_idle", 32'(busy), 32'd0);
    valid = 2'b00;
    cycle(1'b1);

    // Reset pulsed on an acceptance cycle in the middle of requester 1's burst.
    valid = 2'b10; last = 2'b00; addr[1] = 32'h100; wdata[1] = 32'h41;
    cycle(1'b1);
    chk("mid_grant1", 32'(grant), 32'd1);
    cycle(1'b1);
    wdata[1] = 32'h42;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 2'b00;
    cycle(1'b1);
    chk("post_rst_wren", 32'(wren), 32'd0);
    valid = 2'b11; last = 2'b11; addr[0] = 32'h100; addr[1] = 32'h100;
    cycle(1'b1);
    chk("post_rst_rr", 32'(grant), 32'd0);
    cycle(1'b1);
    valid = 2'b00;
    cycle(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      valid = ($urandom_range(0, 9) < 3) ? 2'b00 : 2'($urandom_range(0, 3));
      for (int g = 0; g < 2; g++) begin
        last[g]  = ($urandom_range(0, 2) == 0);
        addr[g]  = {21'h0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
        wdata[g] = $urandom;
      end
      cycle(1'b1);
    end
    valid = 2'b00;
    for (int i = 0; i < TO + 2; i++) cycle(1'b1);

    // Drop counter saturation: a long burst of illegal beats.
    valid = 2'b01; last = 2'b00; addr[0] = 32'h700;
    cycle(1'b1);
    for (int i = 0; i < 65537; i++) begin
      wdata[0] = 32'(i);
      cycle(1'b0);
    end
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
    last = 2'b01;
    cycle(1'b1);
    chk("drop_sat_hold", 32'(drop_cnt), 32'hFFFF);
    chk("sat_no_wren", 32'(wren), 32'd0);
    valid = 2'b00;
    cycle(1'b1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
